// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with operand forwarding, load-use
// bubble insertion, stall/flush handling and a bubble performance counter.
module id_ex_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            flush,
  input  logic            in_valid,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic [XLEN-1:0] in_imm,
  input  logic [4:0]      in_rs1_addr,
  input  logic [4:0]      in_rs2_addr,
  input  logic [4:0]      in_rd_addr,
  input  logic            in_uses_rs1,
  input  logic            in_uses_rs2,
  input  logic [3:0]      in_alu_op,
  input  logic [2:0]      in_funct3,
  input  logic [6:0]      in_funct7,
  input  logic            in_src_a_pc,
  input  logic            in_src_b_imm,
  input  logic            in_reg_write,
  input  logic            in_mem_read,
  input  logic            in_mem_write,
  input  logic            exm_reg_write,
  input  logic [4:0]      exm_rd_addr,
  input  logic [XLEN-1:0] exm_result,
  input  logic            wb_reg_write,
  input  logic [4:0]      wb_rd_addr,
  input  logic [XLEN-1:0] wb_result,
  output logic            ex_valid,
  output logic [XLEN-1:0] operand_a,
  output logic [XLEN-1:0] operand_b,
  output logic [3:0]      alu_op,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [XLEN-1:0] ex_store_data,
  output logic [XLEN-1:0] ex_pc,
  output logic [4:0]      ex_rd_addr,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            hazard_stall,
  output logic [31:0]     bubble_count
);

  logic            valid_r;
  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] rs1_data_r;
  logic [XLEN-1:0] rs2_data_r;
  logic [XLEN-1:0] imm_r;
  logic [4:0]      rs1_addr_r;
  logic [4:0]      rs2_addr_r;
  logic [4:0]      rd_addr_r;
  logic [3:0]      alu_op_r;
  logic [2:0]      funct3_r;
  logic [6:0]      funct7_r;
  logic            src_a_pc_r;
  logic            src_b_imm_r;
  logic            reg_write_r;
  logic            mem_read_r;
  logic            mem_write_r;
  logic [31:0]     bubble_count_r;

  logic            hazard_s;
  logic [XLEN-1:0] fwd_rs1_s;
  logic [XLEN-1:0] fwd_rs2_s;

  // Forward source selection: x0 is hard zero, EX/MEM beats MEM/WB.
  function automatic logic [XLEN-1:0] fwd_sel(
    input logic [4:0]      rs_addr,
    input logic [XLEN-1:0] rs_data,
    input logic            exm_we,
    input logic [4:0]      exm_rd,
    input logic [XLEN-1:0] exm_val,
    input logic            wb_we,
    input logic [4:0]      wb_rd,
    input logic [XLEN-1:0] wb_val
  );
    logic [XLEN-1:0] res;
    if (rs_addr == 5'd0) begin
      res = {XLEN{1'b0}};
    end else if (exm_we && (exm_rd == rs_addr)) begin
      res = exm_val;
    end else if (wb_we && (wb_rd == rs_addr)) begin
      res = wb_val;
    end else begin
      res = rs_data;
    end
    return res;
  endfunction

  // Load-use detection against the load currently held in EX.
  always_comb begin
    hazard_s = 1'b0;
    if (in_valid && valid_r && mem_read_r && (rd_addr_r != 5'd0)) begin
      hazard_s = (in_uses_rs1 && (in_rs1_addr == rd_addr_r)) ||
                 (in_uses_rs2 && (in_rs2_addr == rd_addr_r));
    end else begin
      hazard_s = 1'b0;
    end
  end

  // Pipeline register update: flush > stall > bubble > capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r     <= 1'b0;
      pc_r        <= {XLEN{1'b0}};
      rs1_data_r  <= {XLEN{1'b0}};
      rs2_data_r  <= {XLEN{1'b0}};
      imm_r       <= {XLEN{1'b0}};
      rs1_addr_r  <= 5'd0;
      rs2_addr_r  <= 5'd0;
      rd_addr_r   <= 5'd0;
      alu_op_r    <= 4'd0;
      funct3_r    <= 3'd0;
      funct7_r    <= 7'd0;
      src_a_pc_r  <= 1'b0;
      src_b_imm_r <= 1'b0;
      reg_write_r <= 1'b0;
      mem_read_r  <= 1'b0;
      mem_write_r <= 1'b0;
    end else if (flush) begin
      valid_r     <= 1'b0;
      reg_write_r <= 1'b0;
      mem_read_r  <= 1'b0;
      mem_write_r <= 1'b0;
    end else if (!stall) begin
      if (hazard_s) begin
        valid_r     <= 1'b0;
        reg_write_r <= 1'b0;
        mem_read_r  <= 1'b0;
        mem_write_r <= 1'b0;
        src_a_pc_r  <= 1'b0;
        src_b_imm_r <= 1'b0;
        alu_op_r    <= 4'b0000;
        rs1_addr_r  <= 5'd0;
        rs2_addr_r  <= 5'd0;
      end else begin
        valid_r     <= in_valid;
        pc_r        <= in_pc;
        rs1_data_r  <= in_rs1_data;
        rs2_data_r  <= in_rs2_data;
        imm_r       <= in_imm;
        rs1_addr_r  <= in_rs1_addr;
        rs2_addr_r  <= in_rs2_addr;
        rd_addr_r   <= in_rd_addr;
        alu_op_r    <= in_alu_op;
        funct3_r    <= in_funct3;
        funct7_r    <= in_funct7;
        src_a_pc_r  <= in_src_a_pc;
        src_b_imm_r <= in_src_b_imm;
        reg_write_r <= in_reg_write & in_valid;
        mem_read_r  <= in_mem_read & in_valid;
        mem_write_r <= in_mem_write & in_valid;
      end
    end
  end

  // Bubble counter: counts only bubbles actually inserted (wraps naturally).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_count_r <= 32'd0;
    end else if (!flush && !stall && hazard_s) begin
      bubble_count_r <= bubble_count_r + 32'd1;
    end
  end

  // Live forwarding and operand select from the registered instruction.
  always_comb begin
    fwd_rs1_s = fwd_sel(rs1_addr_r, rs1_data_r, exm_reg_write, exm_rd_addr,
                        exm_result, wb_reg_write, wb_rd_addr, wb_result);
    fwd_rs2_s = fwd_sel(rs2_addr_r, rs2_data_r, exm_reg_write, exm_rd_addr,
                        exm_result, wb_reg_write, wb_rd_addr, wb_result);
    if (src_a_pc_r) begin
      operand_a = pc_r;
    end else begin
      operand_a = fwd_rs1_s;
    end
    if (src_b_imm_r) begin
      operand_b = imm_r;
    end else begin
      operand_b = fwd_rs2_s;
    end
  end

  assign ex_store_data = fwd_rs2_s;
  assign ex_valid      = valid_r;
  assign alu_op        = alu_op_r;
  assign funct3        = funct3_r;
  assign funct7        = funct7_r;
  assign ex_pc         = pc_r;
  assign ex_rd_addr    = rd_addr_r;
  assign ex_reg_write  = reg_write_r & valid_r;
  assign ex_mem_read   = mem_read_r & valid_r;
  assign ex_mem_write  = mem_write_r & valid_r;
  assign hazard_stall  = hazard_s;
  assign bubble_count  = bubble_count_r;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed plus randomized checks of id_ex_stage against a
// cycle-level behavioural model of the pipeline slot.
module tb_id_ex_stage;
  logic        clk = 1'b0;
  logic        rst_n, stall, flush, in_valid;
  logic [31:0] in_pc, in_rs1_data, in_rs2_data, in_imm;
  logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
  logic        in_uses_rs1, in_uses_rs2;
  logic [3:0]  in_alu_op;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic        in_src_a_pc, in_src_b_imm, in_reg_write, in_mem_read, in_mem_write;
  logic        exm_reg_write, wb_reg_write;
  logic [4:0]  exm_rd_addr, wb_rd_addr;
  logic [31:0] exm_result, wb_result;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, hazard_stall;
  logic [31:0] operand_a, operand_b, ex_store_data, ex_pc, bubble_count;
  logic [3:0]  alu_op;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  ex_rd_addr;

  int checks = 0;
  int errors = 0;

  // Model of the instruction occupying the EX slot.
  logic        m_valid, m_srca, m_srcb, m_rw, m_mr, m_mw;
  logic [31:0] m_pc, m_rs1d, m_rs2d, m_imm, m_bub;
  logic [4:0]  m_rs1a, m_rs2a, m_rd;
  logic [3:0]  m_op;
  logic [2:0]  m_f3;
  logic [6:0]  m_f7;

  id_ex_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_rd_addr(in_rd_addr),
    .in_uses_rs1(in_uses_rs1), .in_uses_rs2(in_uses_rs2), .in_alu_op(in_alu_op),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_src_a_pc(in_src_a_pc),
    .in_src_b_imm(in_src_b_imm), .in_reg_write(in_reg_write), .in_mem_read(in_mem_read),
    .in_mem_write(in_mem_write), .exm_reg_write(exm_reg_write), .exm_rd_addr(exm_rd_addr),
    .exm_result(exm_result), .wb_reg_write(wb_reg_write), .wb_rd_addr(wb_rd_addr),
    .wb_result(wb_result), .ex_valid(ex_valid), .operand_a(operand_a), .operand_b(operand_b),
    .alu_op(alu_op), .funct3(funct3), .funct7(funct7), .ex_store_data(ex_store_data),
    .ex_pc(ex_pc), .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .hazard_stall(hazard_stall),
    .bubble_count(bubble_count)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_fwd(input logic [4:0] a, input logic [31:0] d);
    if (a == 5'd0) return 32'd0;
    if (exm_reg_write && exm_rd_addr == a) return exm_result;
    if (wb_reg_write && wb_rd_addr == a) return wb_result;
    return d;
  endfunction

  function automatic logic ref_hazard();
    // A valid load in EX whose destination the incoming instruction reads.
    if (!(in_valid && m_valid && m_mr) || m_rd == 5'd0) return 1'b0;
    return (in_uses_rs1 && in_rs1_addr == m_rd) || (in_uses_rs2 && in_rs2_addr == m_rd);
  endfunction

  task automatic model_clear();
    {m_valid, m_srca, m_srcb, m_rw, m_mr, m_mw} = 6'd0;
    {m_pc, m_rs1d, m_rs2d, m_imm, m_bub} = {5{32'd0}};
    {m_rs1a, m_rs2a, m_rd} = 15'd0;
    m_op = 4'd0; m_f3 = 3'd0; m_f7 = 7'd0;
  endtask

  task automatic model_edge();
    logic hz;
    hz = ref_hazard();
    if (!rst_n) model_clear();
    else if (flush) begin
      m_valid = 1'b0; m_rw = 1'b0; m_mr = 1'b0; m_mw = 1'b0;
    end else if (stall) begin
      m_valid = m_valid;
    end else if (hz) begin
      m_valid = 1'b0; m_rw = 1'b0; m_mr = 1'b0; m_mw = 1'b0;
      m_srca = 1'b0; m_srcb = 1'b0; m_op = 4'd0; m_rs1a = 5'd0; m_rs2a = 5'd0;
      m_bub = m_bub + 32'd1;
    end else begin
      m_valid = in_valid; m_pc = in_pc; m_rs1d = in_rs1_data; m_rs2d = in_rs2_data;
      m_imm = in_imm; m_rs1a = in_rs1_addr; m_rs2a = in_rs2_addr; m_rd = in_rd_addr;
      m_op = in_alu_op; m_f3 = in_funct3; m_f7 = in_funct7;
      m_srca = in_src_a_pc; m_srcb = in_src_b_imm;
      m_rw = in_reg_write & in_valid; m_mr = in_mem_read & in_valid;
      m_mw = in_mem_write & in_valid;
    end
  endtask

  task automatic check_outputs();
    check_val("ex_valid", ex_valid, m_valid);
    check_val("operand_a", operand_a, m_srca ? m_pc : ref_fwd(m_rs1a, m_rs1d));
    check_val("operand_b", operand_b, m_srcb ? m_imm : ref_fwd(m_rs2a, m_rs2d));
    check_val("store_data", ex_store_data, ref_fwd(m_rs2a, m_rs2d));
    check_val("alu_op", alu_op, m_op);
    check_val("funct3", funct3, m_f3);
    check_val("funct7", funct7, m_f7);
    check_val("ex_pc", ex_pc, m_pc);
    check_val("ex_rd_addr", ex_rd_addr, m_rd);
    check_val("ex_reg_write", ex_reg_write, m_rw & m_valid);
    check_val("ex_mem_read", ex_mem_read, m_mr & m_valid);
    check_val("ex_mem_write", ex_mem_write, m_mw & m_valid);
    check_val("hazard_stall", hazard_stall, ref_hazard());
    check_val("bubble_count", bubble_count, m_bub);
  endtask

  // Check at the falling edge, advance the model at the rising edge.
  task automatic step();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_idle();
    stall = 1'b0; flush = 1'b0; in_valid = 1'b0;
    in_pc = 32'd0; in_rs1_data = 32'd0; in_rs2_data = 32'd0; in_imm = 32'd0;
    in_rs1_addr = 5'd0; in_rs2_addr = 5'd0; in_rd_addr = 5'd0;
    in_uses_rs1 = 1'b0; in_uses_rs2 = 1'b0; in_alu_op = 4'd0; in_funct3 = 3'd0;
    in_funct7 = 7'd0; in_src_a_pc = 1'b0; in_src_b_imm = 1'b0;
    in_reg_write = 1'b0; in_mem_read = 1'b0; in_mem_write = 1'b0;
    exm_reg_write = 1'b0; exm_rd_addr = 5'd0; exm_result = 32'd0;
    wb_reg_write = 1'b0; wb_rd_addr = 5'd0; wb_result = 32'd0;
  endtask

  task automatic rand_inputs();
    stall = ($urandom_range(0, 7) == 0);
    flush = ($urandom_range(0, 11) == 0);
    in_valid = ($urandom_range(0, 3) != 0);
    in_pc = $urandom; in_rs1_data = $urandom; in_rs2_data = $urandom; in_imm = $urandom;
    in_rs1_addr = 5'($urandom_range(0, 3)); in_rs2_addr = 5'($urandom_range(0, 3));
    in_rd_addr = 5'($urandom_range(0, 3));
    in_uses_rs1 = 1'($urandom); in_uses_rs2 = 1'($urandom);
    in_alu_op = 4'($urandom); in_funct3 = 3'($urandom); in_funct7 = 7'($urandom);
    in_src_a_pc = ($urandom_range(0, 3) == 0); in_src_b_imm = 1'($urandom);
    in_reg_write = 1'($urandom); in_mem_read = 1'($urandom); in_mem_write = 1'($urandom);
    exm_reg_write = 1'($urandom); exm_rd_addr = 5'($urandom_range(0, 3));
    exm_result = $urandom;
    wb_reg_write = 1'($urandom); wb_rd_addr = 5'($urandom_range(0, 3));
    wb_result = $urandom;
  endtask

  initial begin
    set_idle();
    model_clear();
    rst_n = 1'b0;

    // Reset with random inputs: everything stays zero.
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      step();
    end
    check_val("rst_operand_a", operand_a, 32'd0);
    check_val("rst_bubble", bubble_count, 32'd0);
    set_idle();
    rst_n = 1'b1;

    // First capture after reset.
    in_valid = 1'b1; in_alu_op = 4'b0001; in_rs1_addr = 5'd1; in_rs2_addr = 5'd2;
    in_rs1_data = 32'd5; in_rs2_data = 32'd3;
    step();
    check_val("first_valid", ex_valid, 32'd1);
    check_val("first_op_a", operand_a, 32'd5);
    check_val("first_op_b", operand_b, 32'd3);
    check_val("first_alu_op", alu_op, 32'd1);

    // Forwarding priority on a held rs1 = x7.
    set_idle();
    in_valid = 1'b1; in_rs1_addr = 5'd7; in_uses_rs1 = 1'b1; in_rs1_data = 32'h1234;
    step();
    stall = 1'b1; in_valid = 1'b0;
    exm_reg_write = 1'b1; exm_rd_addr = 5'd7; exm_result = 32'hAAAA;
    wb_reg_write = 1'b1; wb_rd_addr = 5'd7; wb_result = 32'hBBBB;
    #1 check_val("fwd_exm", operand_a, 32'hAAAA);
    step();
    exm_reg_write = 1'b0;
    #1 check_val("fwd_wb", operand_a, 32'hBBBB);
    step();
    wb_reg_write = 1'b0;
    #1 check_val("fwd_none", operand_a, 32'h1234);
    set_idle();
    in_valid = 1'b1; in_rs1_addr = 5'd0; in_rs1_data = 32'h55;
    step();
    stall = 1'b1; exm_reg_write = 1'b1; exm_rd_addr = 5'd0; exm_result = 32'h99;
    #1 check_val("fwd_x0", operand_a, 32'd0);
    step();

    // Load-use: lw x5 then add reading x5.
    set_idle();
    in_valid = 1'b1; in_mem_read = 1'b1; in_reg_write = 1'b1; in_rd_addr = 5'd5;
    step();
    set_idle();
    in_valid = 1'b1; in_uses_rs1 = 1'b1; in_rs1_addr = 5'd5; in_reg_write = 1'b1;
    in_rd_addr = 5'd6;
    #1 check_val("lu_hazard", hazard_stall, 32'd1);
    step();
    check_val("lu_bubble_valid", ex_valid, 32'd0);
    check_val("lu_bubble_rw", ex_reg_write, 32'd0);
    check_val("lu_bubble_cnt", bubble_count, 32'd1);
    check_val("lu_hazard_gone", hazard_stall, 32'd0);
    step();
    check_val("lu_add_valid", ex_valid, 32'd1);
    check_val("lu_add_rd", ex_rd_addr, 32'd6);

    // Stall for three cycles with live forwarding, then stall+flush.
    stall = 1'b1; in_rd_addr = 5'd9;
    for (int i = 0; i < 3; i++) begin
      exm_reg_write = 1'b1; exm_rd_addr = 5'd5; exm_result = $urandom;
      step();
      check_val("stall_hold_rd", ex_rd_addr, 32'd6);
    end
    flush = 1'b1;
    step();
    check_val("stall_flush_valid", ex_valid, 32'd0);

    // PC / immediate select with forwarded store data.
    set_idle();
    in_valid = 1'b1; in_src_a_pc = 1'b1; in_pc = 32'h100; in_src_b_imm = 1'b1;
    in_imm = 32'h20; in_rs2_addr = 5'd3; in_rs2_data = 32'h77; in_mem_write = 1'b1;
    exm_reg_write = 1'b1; exm_rd_addr = 5'd3; exm_result = 32'hCAFE;
    step();
    check_val("sel_op_a", operand_a, 32'h100);
    check_val("sel_op_b", operand_b, 32'h20);
    check_val("sel_store", ex_store_data, 32'hCAFE);

    // Counter wrap from all-ones.
    set_idle();
    force dut.bubble_count_r = 32'hFFFF_FFFF;
    #1 release dut.bubble_count_r;
    m_bub = 32'hFFFF_FFFF;
    in_valid = 1'b1; in_mem_read = 1'b1; in_reg_write = 1'b1; in_rd_addr = 5'd4;
    step();
    set_idle();
    in_valid = 1'b1; in_uses_rs2 = 1'b1; in_rs2_addr = 5'd4;
    step();
    check_val("wrap_cnt", bubble_count, 32'd0);

    // Randomized traffic with occasional asynchronous reset.
    for (int i = 0; i < 2000; i++) begin
      rand_inputs();
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 199) == 0) begin
        rst_n = 1'b0;
        model_clear();
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
